peak_window_meter: RTL

PEAK_WINDOW_METER -- requirements
Module: peak_window_meter

---
 rtl/peak_window_meter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/peak_window_meter.sv
// Frame-based envelope statistics: peak, trough, peak-to-peak and mean over
// 2^FRAME_LOG2 qualified samples, with one-shot or continuous re-arming.
module peak_window_meter #(
   parameter int unsigned FRAME_LOG2 = 10,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [11:0] in,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic signed [11:0] peak,
   output logic signed [11:0] trough,
   output logic        [12:0] pk2pk,
   output logic signed [11:0] avg
);

   localparam int unsigned DW = 12;
   localparam int unsigned CW = FRAME_LOG2 + 1;
   localparam int unsigned AW = DW + FRAME_LOG2;
   localparam logic [CW-1:0] LAST = {1'b1, {FRAME_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt_q;
   logic signed [AW-1:0] acc_q;
   logic                 have_q;
   logic signed [DW-1:0] max_q;
   logic signed [DW-1:0] min_q;

   logic [CW-1:0]        cnt_n;
   logic signed [AW-1:0] acc_n;
   logic signed [DW-1:0] max_n;
   logic signed [DW-1:0] min_n;
   logic        [DW:0]   span_n;
   logic signed [DW-1:0] avg_n;
   logic                 arm;

   // Running statistics as they would stand after accepting the current sample.
   always_comb begin
      max_n = max_q;
      min_n = min_q;
      if (!have_q || (in > max_q)) max_n = in;
      if (!have_q || (in < min_q)) min_n = in;
      acc_n  = acc_q + {{FRAME_LOG2{in[DW-1]}}, in};
      cnt_n  = cnt_q + CW'(1);
      span_n = {max_n[DW-1], max_n} - {min_n[DW-1], min_n};
      avg_n  = DW'(acc_n >>> FRAME_LOG2);
      arm    = start || CONTINUOUS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         peak   <= '0;
         trough <= '0;
         pk2pk  <= '0;
         avg    <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
         have_q <= 1'b0;
         max_q  <= '0;
         min_q  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (arm) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  have_q <= 1'b0;
               end
            end
            RUN: begin
               if (in_valid) begin
                  max_q  <= max_n;
                  min_q  <= min_n;
                  acc_q  <= acc_n;
                  cnt_q  <= cnt_n;
                  have_q <= 1'b1;
                  // Last sample of the frame: publish results on this edge.
                  if (cnt_n == LAST) begin
                     state  <= DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     peak   <= max_n;
                     trough <= min_n;
                     pk2pk  <= span_n;
                     avg    <= avg_n;
                  end
               end
            end
            DONE: begin
               if (arm) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  have_q <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
